fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//   Instruction-fetch front end; reads from the address held in pc_counter and drives its PC_next input.
//   Issues req/ack reads to instruction memory at the current PC.
//   Buffers returned words with their PC in a small FIFO and hands them to decode over valid/ready.
//   Handles branch/jump redirects, including discarding a read already in flight.
// PARAMETERS
//   ADDRESS_WIDTH  32  width of PC, memory address, instr_pc_o
//   INSTR_WIDTH    32  width of instruction word
//   FIFO_DEPTH     2   fetch buffer entries (power of 2, >=2)
// PORTS
//   clk              in   1              rising-edge clock
//   rst              in   1              reset, asynchronous, active-low
//   pc_i             in   ADDRESS_WIDTH  current PC (pc_counter address_o)
//   pc_next_o        out  ADDRESS_WIDTH  next PC (pc_counter PC_next), combinational
//   mem_req_o        out  1              read request, registered
//   mem_addr_o       out  ADDRESS_WIDTH  read address, registered
//   mem_ack_i        in   1              read done; mem_rdata_i valid this cycle
//   mem_rdata_i      in   INSTR_WIDTH    read data
//   redirect_i       in   1              flush and restart fetch at redirect_addr_i
//   redirect_addr_i  in   ADDRESS_WIDTH  redirect target; bits [1:0] forced to 0
//   instr_valid_o    out  1              FIFO head valid
//   instr_ready_i    in   1              decode accepts head
//   instr_o          out  INSTR_WIDTH    head instruction
//   instr_pc_o       out  ADDRESS_WIDTH  PC of head instruction
// BEHAVIOUR
//   Reset (rst=0, async)
//     - mem_req_o=0, mem_addr_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
//     - FIFO count=0; state=S_IDLE.
//   States and transitions
//     - S_IDLE -> S_FETCH on the first edge after reset release.
//     - S_FETCH: normal fetch.
//     - S_DRAIN: a redirect hit while a read was outstanding; wait for that ack.
//     - S_DRAIN -> S_FETCH on the edge that mem_ack_i=1.
//   Request rules
//     - One read outstanding max. Once mem_req_o=1, it and mem_addr_o stay stable until the edge with mem_ack_i=1.
//     - A new request launches when all hold at an edge: state is S_FETCH (or S_IDLE exiting), no read outstanding (or the outstanding one is acked at this edge), and FIFO count after this edge < FIFO_DEPTH.
//     - Launch sets mem_req_o<=1 and mem_addr_o<=pc_next_o. mem_addr_o therefore equals the PC being loaded into pc_counter.
//     - Back-to-back reads: ack at edge N, new request visible after edge N.
//   PC rules (pc_next_o, priority order)
//     - rst=0: pc_next_o=pc_i.
//     - redirect_i=1: pc_next_o={redirect_addr_i[AW-1:2],2'b00}.
//     - mem_ack_i=1 with a live read (not S_DRAIN): pc_next_o=pc_i+4, wraps modulo 2^ADDRESS_WIDTH.
//     - Otherwise: pc_next_o=pc_i (hold).
//   FIFO
//     - Ack of a live read pushes {mem_addr_o, mem_rdata_i}.
//     - instr_valid_o && instr_ready_i pops.
//     - Push and pop in the same cycle are both allowed; count is unchanged.
//     - Push into a full FIFO cannot occur (space is reserved at launch); assert on it.
//     - Output latency: ack at edge N -> instr_valid_o=1 after edge N (FIFO was empty).
//     - Order is strictly preserved.
//   Redirect (sampled at edge)
//     - FIFO is flushed (count=0); a pop in the same cycle is ignored.
//     - No read outstanding: new request issues at the same edge with addr = target.
//     - Read outstanding and acked at the same edge: data is discarded; new request issues at the same edge with addr = target.
//     - Read outstanding and not acked: go to S_DRAIN. mem_req_o and mem_addr_o are held. Ack data is discarded. The next request (addr = pc_i = target) issues on the ack edge.
//     - Redirect while in S_DRAIN: updates pc_next_o only; stay in S_DRAIN.
//   Reset mid-read: all state is cleared immediately. The memory must tolerate a req drop without ack.
// TESTING
//   T1 zero-wait (ack=1 whenever req=1), ready=1 -> mem_addr_o 0x0,0x4,0x8; instr_valid_o every cycle, instr_pc_o 0x0,0x4,0x8.
//   T2 ack after 3 cycles -> mem_req_o=1 and mem_addr_o=0x10 stable for 3 cycles; pc_next_o=pc_i=0x10 until ack, then 0x14.
//   T3 ready=0, depth 2 -> entries 0x0,0x4 held, mem_req_o=0, pc_i=0x8; ready=1 -> pops 0x0,0x4, then fetches 0x8.
//   T4 redirect to 0x103 with read at 0x8 pending -> pc_next_o=0x100; instr_valid_o=0; S_DRAIN; late ack data dropped; next mem_addr_o=0x100.
//   T5 redirect to 0x200 at same edge as ack of 0xC -> 0xC never appears on instr_o; mem_addr_o=0x200 immediately.
//   T6 rst low mid-read, pc wraps: from 0xFFFFFFFC next PC is 0x0; reset -> mem_req_o=0, instr_valid_o=0 without a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: issues one-at-a-time reads at the current PC, buffers returned
// words with their PC in a small FIFO for decode, and handles redirects, including discarding a
// read that is already in flight when the redirect hits.
module fetch_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    output logic [ADDRESS_WIDTH-1:0] pc_next_o,
    output logic                     mem_req_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [INSTR_WIDTH-1:0]   mem_rdata_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_addr_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [INSTR_WIDTH-1:0]   instr_o,
    output logic [ADDRESS_WIDTH-1:0] instr_pc_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e                   state_q;
    logic [INSTR_WIDTH-1:0]   data_q [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_q [FIFO_DEPTH];
    logic [PtrW-1:0]          rd_ptr_q;
    logic [PtrW-1:0]          wr_ptr_q;
    logic [CntW-1:0]          count_q;
    logic [CntW-1:0]          count_d;

    logic                     live_read;
    logic                     ack_live;
    logic                     push;
    logic                     pop;
    logic                     launch;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic                     unused_redirect_lsb;

    // Targets are word aligned; the low address bits are dropped.
    assign redirect_target     = {redirect_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_addr_i[1:0];

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = data_q[rd_ptr_q];
    assign instr_pc_o    = addr_q[rd_ptr_q];

    // Handshake decode, FIFO occupancy after this edge and request launch decision.
    always_comb begin
        live_read = mem_req_o && (state_q == StFetch);
        ack_live  = live_read && mem_ack_i;
        push      = ack_live && !redirect_i;
        pop       = instr_valid_o && instr_ready_i && !redirect_i;
        if (redirect_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + {{(CntW-1){1'b0}}, push} - {{(CntW-1){1'b0}}, pop};
        end
        // Space for the returning word is reserved here, so a push never meets a full FIFO.
        launch = 1'b0;
        unique case (state_q)
            StIdle:  launch = 1'b1;
            StFetch: launch = !(mem_req_o && !mem_ack_i) && (count_d < DepthCnt);
            StDrain: launch = mem_ack_i && (count_d < DepthCnt);
            default: launch = 1'b0;
        endcase
    end

    // Next PC for the external pc_counter, in priority order.
    always_comb begin
        pc_next_o = pc_i;
        if (!rst) begin
            pc_next_o = pc_i;
        end else if (redirect_i) begin
            pc_next_o = redirect_target;
        end else if (ack_live) begin
            pc_next_o = pc_i + ADDRESS_WIDTH'(4);
        end
    end

    // Fetch FSM with registered request and address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            unique case (state_q)
                StIdle:  state_q <= StFetch;
                // An unacked read cannot be cancelled; wait for it and drop its data.
                StFetch: if (redirect_i && mem_req_o && !mem_ack_i) state_q <= StDrain;
                StDrain: if (mem_ack_i) state_q <= StFetch;
                default: state_q <= StIdle;
            endcase
            if (launch) begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= pc_next_o;
            end else if (mem_req_o && mem_ack_i) begin
                mem_req_o  <= 1'b0;
            end
        end
    end

    // Fetch buffer: push on live ack, pop on decode handshake, flush on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (redirect_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    data_q[wr_ptr_q] <= mem_rdata_i;
                    addr_q[wr_ptr_q] <= mem_addr_o;
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
            count_q <= count_d;
        end
    end

    push_not_full_a : assert property (@(posedge clk) disable iff (!rst)
        push |-> (count_q < DepthCnt));

endmodule
